module_uart_rx: RTL
===================

MODULE_UART_RX -- requirements
Module: module_uart_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 10_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD, integer division, shall be >= 4.
REQ-003 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_i  input  1  asynchronous serial line, idle high.
REQ-006 data_o  output  32  received word {24'b0, byte}; drives data2_i.data of the UART data register.
REQ-007 wr_o  output  1  one-cycle write strobe; drives wr_2_i of the UART data register.
REQ-008 frame_err_o  output  1  sticky framing/parity error flag.
REQ-009 err_clr_i  input  1  synchronous clear of frame_err_o.
REQ-010 busy_o  output  1  high in every state except IDLE.

Function
REQ-011 rx_i shall pass a 2-flop synchronizer; rx_s denotes the synchronized value, and all sampling shall use rx_s.
REQ-012 FSM states shall be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-013 IDLE -> START on rx_s = 0; the bit counter and clock counter shall clear on entry.
REQ-014 START: after CLKS_PER_BIT/2 cycles, rx_s = 0 -> DATA; rx_s = 1 -> IDLE (glitch rejected, no strobe, no error).
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register; after bit 7 -> PARITY, or -> STOP without the macro.
REQ-016 STOP: sample once CLKS_PER_BIT cycles after the last data/parity sample, then -> IDLE.
REQ-017 On stop = 1 and no parity error, the next cycle shall load data_o = {24'b0, byte} and pulse wr_o high for exactly one cycle.
REQ-018 On stop = 0 or a parity error, wr_o shall stay low, data_o shall be unchanged, and frame_err_o shall set.
REQ-019 data_o shall hold its value between strobes.
REQ-020 frame_err_o shall clear only on err_clr_i = 1 or reset; if err_clr_i and a new error occur in the same cycle, set wins.
REQ-021 A new start bit may be accepted in the cycle after STOP exits (back-to-back frames, no idle gap required).
REQ-022 Latency: wr_o shall rise 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx_i falling edge (+CLKS_PER_BIT with the macro), +/-1 cycle of synchronizer phase.

Reset
REQ-023 rst_i = 0 shall immediately force: FSM = IDLE, counters = 0, shift register = 0, data_o = 0, wr_o = 0, frame_err_o = 0, busy_o = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame shall abort the frame with no strobe; after release, the block shall wait for a fresh falling edge.

Configuration
REQ-025 Macro UART_RX_PARITY_EN: when defined, the PARITY state shall sample one even-parity bit after bit 7, and a mismatch shall be treated as a framing error (REQ-018).
REQ-026 Without UART_RX_PARITY_EN, the frame shall be 8N1, and the PARITY state and its logic shall be absent.

Verification (CLK_FREQ_HZ = 10_000_000, BAUD = 1_000_000, CLKS_PER_BIT = 10)
REQ-027 Frame 0xA5, 8N1 -> single wr_o pulse, data_o = 0x000000A5, frame_err_o = 0, busy_o low afterwards.
REQ-028 Low pulse of 3 clocks on idle rx_i -> return to IDLE, no wr_o, frame_err_o = 0.
REQ-029 Frame 0x3C with stop bit = 0 -> no wr_o, data_o retains previous 0x000000A5, frame_err_o = 1; err_clr_i pulse -> frame_err_o = 0.
REQ-030 Back-to-back frames 0x01, 0xFF with no gap -> two wr_o pulses, 100 cycles apart, data_o = 0x00000001 then 0x000000FF.
REQ-031 rst_i low at bit 4 of frame 0x55, release, then frame 0x12 -> only one wr_o pulse, data_o = 0x00000012.
REQ-032 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> wr_o, data_o = 0x00000007; same byte with parity bit 0 -> frame_err_o = 1, no wr_o.

Source files
------------

// File: rtl/module_uart_rx_if.sv
// Receive-side bus of the UART RX block: received word, write strobe, error flag and busy.
// The master modport is the receiver; the slave modport is the UART data register side.
interface module_uart_rx_if;
  logic [31:0] data_o;
  logic        wr_o;
  logic        frame_err_o;
  logic        err_clr_i;
  logic        busy_o;

  modport master (
    output data_o,
    output wr_o,
    output frame_err_o,
    output busy_o,
    input  err_clr_i
  );

  modport slave (
    input  data_o,
    input  wr_o,
    input  frame_err_o,
    input  busy_o,
    output err_clr_i
  );
endinterface

// File: rtl/module_uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with parity check.
// Oversamples the synchronized line at mid-bit and writes {24'b0, byte} with a one-cycle strobe.
module module_uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD        = 115_200
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  module_uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = 3;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic                rx_s;
  logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                wr_q, wr_d;
  logic                frame_err_q, frame_err_d;
  logic                err_set;
  logic                busy_q;
  logic                bit_tick;
  logic                half_tick;
`ifdef UART_RX_PARITY_EN
  logic                par_err_q, par_err_d;
`endif

  assign rx_s = sync_q[1];

  // Sequential state: synchronizer, FSM, counters, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Next-state and datapath logic; samples land on the last cycle of each bit period.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    err_set   = 1'b0;
    bit_tick  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    half_tick = (clk_cnt_q == CNT_W'(HALF_BIT - 1));
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (half_tick) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(BYTE_W - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      // Even parity: the received bit must equal the XOR of the data byte.
      S_PARITY: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          par_err_d = rx_s ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (bit_tick) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
`ifdef UART_RX_PARITY_EN
          if (rx_s && !par_err_q) begin
`else
          if (rx_s) begin
`endif
            data_d = {(WORD_W - BYTE_W)'(0), shift_q};
            wr_d   = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    // A new error in the same cycle as a clear request keeps the flag set.
    frame_err_d = err_set | (frame_err_q & ~bus.err_clr_i);
  end

  assign bus.data_o      = data_q;
  assign bus.wr_o        = wr_q;
  assign bus.frame_err_o = frame_err_q;
  assign bus.busy_o      = busy_q;

endmodule
